// File: rtl/mpaddsub_mod.sv
// Limb-serial multi-precision adder/subtractor with modular add/sub modes.
// One LIMB-bit add per cycle; modular modes run a fixed second correction pass.
module mpaddsub_mod #(
    parameter int WIDTH = 1027,
    parameter int LIMB  = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   result
);
    // state   | meaning
    // IDLE    | waiting for start
    // PASS1   | a +/- b, one limb per cycle
    // PASS2   | r1 -/+ m correction pass (modes 2/3 only)
    // DONE    | result valid, done pulse
    localparam int NLIMBS = (WIDTH + LIMB - 1) / LIMB;
    localparam int PW     = NLIMBS * LIMB;
    localparam int CW     = $clog2(NLIMBS + 1);

    typedef enum logic [1:0] {S_IDLE, S_PASS1, S_PASS2, S_DONE} state_t;

    state_t         state;
    logic [1:0]     mode_q;
    logic [PW-1:0]  opa;
    logic [PW-1:0]  opb;
    logic [PW-1:0]  opm;
    logic [PW-1:0]  acc;
    logic           carry;
    logic [CW-1:0]  cnt;
    logic [WIDTH:0] r1_q;

    logic           op_sub;
    logic           cin;
    logic [LIMB:0]  limb_sum;
    logic [PW-1:0]  acc_nxt;
    logic [WIDTH:0] sum_full;
    logic           ge_m;
    logic [WIDTH:0] fin;

    always_comb begin
        op_sub   = (state == S_PASS2) ? ~mode_q[0] : mode_q[0];
        cin      = (cnt == CW'(NLIMBS - 1)) ? op_sub : carry;
        limb_sum = {1'b0, opa[LIMB-1:0]}
                 + {1'b0, opb[LIMB-1:0] ^ {LIMB{op_sub}}}
                 + {{LIMB{1'b0}}, cin};
        acc_nxt  = acc >> LIMB;
        acc_nxt[PW-1 -: LIMB] = limb_sum[LIMB-1:0];
    end

    // With an exact fit, bit WIDTH lives outside the datapath and is rebuilt
    // from the top carry; with padding it falls inside the top limb.
    if (PW == WIDTH) begin : g_exact
        logic hi_in;
        assign hi_in    = (state == S_PASS2) & r1_q[WIDTH];
        assign sum_full = {hi_in ^ limb_sum[LIMB] ^ op_sub, acc_nxt[WIDTH-1:0]};
        assign ge_m     = r1_q[WIDTH] | limb_sum[LIMB];
    end else begin : g_padded
        assign sum_full = acc_nxt[WIDTH:0];
        assign ge_m     = limb_sum[LIMB];
    end

    always_comb begin
        fin = sum_full;
        case (mode_q)
            2'd2:    fin = ge_m ? sum_full : r1_q;
            2'd3:    fin = r1_q[WIDTH] ? {1'b0, sum_full[WIDTH-1:0]} : r1_q;
            default: fin = sum_full;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            mode_q <= '0;
            opa    <= '0;
            opb    <= '0;
            opm    <= '0;
            acc    <= '0;
            r1_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mode_q <= mode;
                        opa    <= PW'(in_a);
                        opb    <= PW'(in_b);
                        opm    <= PW'(in_m);
                        carry  <= 1'b0;
                        cnt    <= CW'(NLIMBS - 1);
                        busy   <= 1'b1;
                        state  <= S_PASS1;
                    end
                end
                S_PASS1, S_PASS2: begin
                    acc   <= acc_nxt;
                    opa   <= opa >> LIMB;
                    opb   <= opb >> LIMB;
                    carry <= limb_sum[LIMB];
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) begin
                        if (state == S_PASS1 && mode_q[1]) begin
                            r1_q  <= sum_full;
                            opa   <= PW'(sum_full);
                            opb   <= opm;
                            carry <= 1'b0;
                            cnt   <= CW'(NLIMBS - 1);
                            state <= S_PASS2;
                        end else begin
                            result <= fin;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mpaddsub_mod.sv
// Bench for mpaddsub_mod: three geometries driven in lockstep, checked each cycle
// against an arithmetic reference model plus a few literal expectations.
module tb_mpaddsub_mod;
    localparam int NI = 3;
    localparam int WB = 1100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          start;
    logic [1:0]    mode;
    logic [WB-1:0] sa [NI];
    logic [WB-1:0] sb [NI];
    logic [WB-1:0] sm [NI];

    logic          busy0, busy1, busy2;
    logic          done0, done1, done2;
    logic [1027:0] res0;
    logic [256:0]  res1;
    logic [100:0]  res2;

    mpaddsub_mod #(.WIDTH(1027), .LIMB(64)) u0 (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .in_a(sa[0][1026:0]), .in_b(sb[0][1026:0]), .in_m(sm[0][1026:0]),
        .busy(busy0), .done(done0), .result(res0));
    mpaddsub_mod #(.WIDTH(256), .LIMB(32)) u1 (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .in_a(sa[1][255:0]), .in_b(sb[1][255:0]), .in_m(sm[1][255:0]),
        .busy(busy1), .done(done1), .result(res1));
    mpaddsub_mod #(.WIDTH(100), .LIMB(16)) u2 (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .in_a(sa[2][99:0]), .in_b(sb[2][99:0]), .in_m(sm[2][99:0]),
        .busy(busy2), .done(done2), .result(res2));

    const int W_OF[NI] = '{1027, 256, 100};
    const int N_OF[NI] = '{17, 8, 7};

    logic          bsy [NI];
    logic          dn  [NI];
    logic [WB:0]   rs  [NI];
    always_comb begin
        bsy[0] = busy0; bsy[1] = busy1; bsy[2] = busy2;
        dn[0]  = done0; dn[1]  = done1; dn[2]  = done2;
        rs[0] = '0; rs[0][1027:0] = res0;
        rs[1] = '0; rs[1][256:0]  = res1;
        rs[2] = '0; rs[2][100:0]  = res2;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [WB:0] act, input logic [WB:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (low 400 bits)", name, act[399:0], exp[399:0]);
        end
    endtask

    function automatic logic [WB:0] one_sh(input int s);
        logic [WB:0] one;
        one = 1;
        return one << s;
    endfunction

    function automatic logic [WB-1:0] mask(input int w);
        logic [WB:0] t;
        t = one_sh(w) - 1;
        return t[WB-1:0];
    endfunction

    // Reference: plain big-integer arithmetic from the operation definitions.
    function automatic logic [WB:0] model(input int w, input logic [1:0] md,
                                          input logic [WB-1:0] a, b, m);
        logic [WB:0] ea, eb, em, r;
        ea = {1'b0, a}; eb = {1'b0, b}; em = {1'b0, m};
        case (md)
            2'd0: r = (ea + eb) & (one_sh(w + 1) - 1);
            2'd1: r = (ea - eb) & (one_sh(w + 1) - 1);
            2'd2: begin
                r = ea + eb;
                if (r >= em) r = r - em;
            end
            default: r = (ea >= eb) ? ea - eb : ea + em - eb;
        endcase
        return r;
    endfunction

    function automatic logic [WB-1:0] rnd(input int w);
        logic [1119:0] v;
        for (int k = 0; k < 35; k++) v[k*32 +: 32] = $urandom;
        case ($urandom_range(0, 7))
            0: return mask(w);
            1: return '0;
            2: return v[WB-1:0] & mask(12);
            default: return v[WB-1:0] & mask(w);
        endcase
    endfunction

    task automatic set_all(input logic [WB-1:0] a, b, m);
        for (int i = 0; i < NI; i++) begin
            sa[i] = a; sb[i] = b; sm[i] = m;
        end
    endtask

    // Launch one op on all instances and check busy/done/result every cycle.
    task automatic run_op(input logic [1:0] md, input bit pin, input logic [WB:0] lit0,
                          input string tag, input int poke_cyc);
        logic [WB:0] exp [NI];
        int lat [NI];
        int maxl;
        maxl = 0;
        for (int i = 0; i < NI; i++) begin
            exp[i] = model(W_OF[i], md, sa[i], sb[i], sm[i]);
            lat[i] = md[1] ? 2 * N_OF[i] + 1 : N_OF[i] + 1;
            if (lat[i] > maxl) maxl = lat[i];
        end
        if (pin) chk($sformatf("%s model", tag), exp[0], lit0);
        @(negedge clk);
        mode  = md;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode  = ~md;
        for (int c = 1; c <= maxl + 1; c++) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("%s/%0d busy c%0d", tag, i, c), {{WB{1'b0}}, bsy[i]},
                    (c <= lat[i]) ? 1 : 0);
                chk($sformatf("%s/%0d done c%0d", tag, i, c), {{WB{1'b0}}, dn[i]},
                    (c == lat[i]) ? 1 : 0);
                if (c >= lat[i])
                    chk($sformatf("%s/%0d result c%0d", tag, i, c), rs[i], exp[i]);
            end
            if (c == poke_cyc) begin
                start = 1'b1;
                mode  = md ^ 2'd1;
                for (int i = 0; i < NI; i++) sa[i] = sb[i] ^ 1;
            end
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic reset_test();
        set_all(1000, 2000, 0);
        @(negedge clk);
        mode  = 2'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 5; c++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst/%0d busy", i), {{WB{1'b0}}, bsy[i]}, 0);
            chk($sformatf("rst/%0d done", i), {{WB{1'b0}}, dn[i]}, 0);
            chk($sformatf("rst/%0d result", i), rs[i], 0);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++)
                chk($sformatf("rst/%0d quiet c%0d", i, c), {{WB{1'b0}}, dn[i] | bsy[i]}, 0);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        mode  = 2'd0;
        set_all(0, 0, 0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("init/%0d busy", i), {{WB{1'b0}}, bsy[i]}, 0);
            chk($sformatf("init/%0d done", i), {{WB{1'b0}}, dn[i]}, 0);
            chk($sformatf("init/%0d result", i), rs[i], 0);
        end
        reset = 1'b0;

        set_all(1000, 2000, 0);  run_op(2'd0, 1, 3000, "add", 0);
        set_all(3000, 1500, 0);  run_op(2'd1, 1, 1500, "sub", 0);
        set_all(1500, 3000, 0);  run_op(2'd1, 1, one_sh(1028) - 1500, "sub_borrow", 0);
        for (int i = 0; i < NI; i++) begin
            sa[i] = mask(W_OF[i]); sb[i] = 1; sm[i] = 0;
        end
        run_op(2'd0, 1, one_sh(1027), "add_ripple", 0);

        set_all(1000, 20, 1009); run_op(2'd2, 1, 11, "madd1", 0);
        set_all(5, 6, 1009);     run_op(2'd2, 1, 11, "madd2", 0);
        set_all(504, 505, 1009); run_op(2'd2, 1, 0, "madd3", 0);
        set_all(5, 20, 1009);    run_op(2'd3, 1, 994, "msub1", 0);
        set_all(20, 5, 1009);    run_op(2'd3, 1, 15, "msub2", 0);
        set_all(7, 7, 1009);     run_op(2'd3, 1, 0, "msub3", 0);
        for (int i = 0; i < NI; i++) begin
            sa[i] = 0; sb[i] = 1; sm[i] = mask(W_OF[i]);
        end
        run_op(2'd3, 1, one_sh(1027) - 2, "msub_ripple", 0);

        set_all(1000, 2000, 0);  run_op(2'd0, 1, 3000, "busy_start", 3);
        reset_test();
        set_all(1000, 2000, 0);  run_op(2'd0, 1, 3000, "after_rst", 0);

        for (int md = 0; md < 4; md++) begin
            for (int n = 0; n < 200; n++) begin
                for (int i = 0; i < NI; i++) begin
                    if (md >= 2) begin
                        sm[i] = rnd(W_OF[i]);
                        if (sm[i] == '0) sm[i] = 1;
                        sa[i] = rnd(W_OF[i]) % sm[i];
                        sb[i] = rnd(W_OF[i]) % sm[i];
                    end else begin
                        sa[i] = rnd(W_OF[i]);
                        sb[i] = rnd(W_OF[i]);
                        sm[i] = rnd(W_OF[i]);
                    end
                end
                run_op(2'(md), 0, '0, $sformatf("rnd_m%0d_%0d", md, n), 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
